// File: rtl/data_memory_pkg.sv
// Shared widths, word type and reset value for the data memory.
package data_memory_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] word_t;

  localparam word_t WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/data_memory_rst_sync.sv
// Reset deassertion synchroniser: asserts asynchronously, releases on clk.
module data_memory_rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic stage_r;

  // First stage captures the release on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= 1'b0;
    end else begin
      stage_r <= 1'b1;
    end
  end

  // Second stage resolves on the falling edge, so release is visible before the
  // second rising edge after rst_n rises, whichever half-cycle the release fell in.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_n <= 1'b0;
    end else begin
      rst_sync_n <= stage_r;
    end
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, async clear.
// Optional macro DMEM_RANGE_CHECK_EN adds addr_err and blocks out-of-range access.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DATA_W-1:0] RESET_WORD = DATA_W'(WORD_ZERO);

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] index_s;
  logic                  rst_sync_n;
  logic                  range_err_s;
  logic                  wr_en_s;

  data_memory_rst_sync u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  assign index_s = addr[DEPTH_LOG2-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err_s = rst_n & (|addr[ADDR_W-1:DEPTH_LOG2]);
  assign addr_err    = range_err_s;
`else
  // Upper address bits alias onto the array.
  logic unused_upper_s;
  assign unused_upper_s = ^addr[ADDR_W-1:DEPTH_LOG2];
  assign range_err_s    = 1'b0;
`endif

  assign wr_en_s = we & rst_sync_n & ~range_err_s;

  // Storage array: whole-array clear on reset, single write port otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_WORD;
      end
    end else if (wr_en_s) begin
      mem_r[index_s] <= data_in;
    end else begin
      mem_r[index_s] <= mem_r[index_s];
    end
  end

  // Combinational read with no write bypass.
  always_comb begin
    data_out = RESET_WORD;
    if (range_err_s) begin
      data_out = RESET_WORD;
    end else begin
      data_out = mem_r[index_s];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table plus reset sequences.
`timescale 1ns/100ps
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
`ifdef DMEM_RANGE_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] exp_pre;
  } vec_t;

  vec_t vecs[$];

  data_memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .addr_err (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic [31:0] e);
    vec_t v;
    v.name = n; v.addr = a; v.din = d; v.we = w; v.exp_pre = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] wrap_exp;
`ifdef DMEM_RANGE_CHECK_EN
    wrap_exp = 32'h0000_0000;
`else
    wrap_exp = 32'h0000_0055;
`endif
    // Each vector: inputs applied after negedge, data_out checked before the rising edge.
    for (int i = 0; i < 4; i++) add("ro_sweep", 32'(i), 32'd1, 1'b0, 32'd0);
    add("wr_a1",      32'd1,   32'd1,   1'b1, 32'd0);
    add("wr_a2",      32'd2,   32'd10,  1'b1, 32'd0);
    add("rd_a3",      32'd3,   32'd0,   1'b0, 32'd0);
    add("rd_a0",      32'd0,   32'd0,   1'b0, 32'd0);
    add("rd_a2",      32'd2,   32'd0,   1'b0, 32'd10);
    add("rd_a1",      32'd1,   32'd0,   1'b0, 32'd1);
    add("wr_a5_7",    32'd5,   32'd7,   1'b1, 32'd0);
    add("rdw_old",    32'd5,   32'hDEADBEEF, 1'b1, 32'd7);
    add("rdw_new",    32'd5,   32'd0,   1'b0, 32'hDEADBEEF);
    add("wr_a256",    32'd256, 32'h55,  1'b1, 32'd0);
    add("rd_a0_wrap", 32'd0,   32'd0,   1'b0, wrap_exp);
    add("rd_a256",    32'd256, 32'd0,   1'b0, wrap_exp);
`ifdef DMEM_RANGE_CHECK_EN
    add("rd_a261",    32'd261, 32'd0,   1'b0, 32'd0);
`else
    add("rd_a261",    32'd261, 32'd0,   1'b0, 32'hDEADBEEF);
`endif

    // Power-up reset
    rst_n = 1'b0; we = 1'b0; addr = 32'd0; data_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i);
      #1;
      chk($sformatf("por_rd%0d", i), data_out, 32'd0);
    end
`ifdef DMEM_RANGE_CHECK_EN
    addr = 32'd256;
    #0.5;
    chk("por_addr_err", {31'd0, addr_err}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      addr = vecs[k].addr; data_in = vecs[k].din; we = vecs[k].we;
      #1;
      chk(vecs[k].name, data_out, vecs[k].exp_pre);
    end
    @(negedge clk);
    we = 1'b0;

`ifdef DMEM_RANGE_CHECK_EN
    addr = 32'd256;         #1; chk("err_256", {31'd0, addr_err}, 32'd1);
    addr = 32'd255;         #1; chk("err_255", {31'd0, addr_err}, 32'd0);
    addr = 32'h8000_0000;   #1; chk("err_msb", {31'd0, addr_err}, 32'd1);
`endif

    // Fill 0..3 with 1..4
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = 32'(i); data_in = 32'(i + 1); we = 1'b1;
    end
    @(negedge clk);
    we = 1'b0; addr = 32'd3;
    #1;
    chk("fill_a3", data_out, 32'd4);

    // Half-cycle reset pulse with a write pending
    addr = 32'd0; data_in = 32'd99; we = 1'b1;
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i);
      #0.5;
      chk($sformatf("mid_rst_rd%0d", i), data_out, 32'd0);
    end
    addr = 32'd0;
    @(posedge clk);
    #1;
    chk("rst_discard", data_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_edge1", data_out, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_edge2", data_out, 32'd99);
    we = 1'b0; addr = 32'd1;
    #1;
    chk("rel_a1_clr", data_out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
